// File: rtl/audio_pkg.sv
// Shared constants for the audio sample source: register map, CSR bit
// positions, sample packing width and the triangle tone shaping helper.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [1:0] ADDR_CSR  = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_TONE = 2'd2;

  localparam int CSR_ENABLE   = 0;
  localparam int CSR_FLUSH    = 1;
  localparam int CSR_CLEAR    = 2;
  localparam int CSR_UNDERRUN = 2;
  localparam int CSR_OVERFLOW = 3;
  localparam int CSR_COUNT_LO = 8;
  localparam int CSR_LEVEL_LO = 16;

  localparam int TONE_SEL_BIT = 31;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_ACK  = 1'b1
  } wb_state_t;

  // Fold a 16-bit phase into a triangle-shaped sample; the top phase bit
  // selects the falling half, which is the bitwise inverse of the rising half.
  function automatic logic [SAMPLE_W-1:0] tri_sample(input logic [15:0] phase);
    logic [SAMPLE_W-1:0] ramp;
    ramp = {phase[14:0], 1'b0} ^ 16'h8000;
    return phase[15] ? ~ramp : ramp;
  endfunction

endpackage

// File: rtl/audio_fifo.sv
// Synchronous sample-pair FIFO on a registered-read (EBR style) 32-bit memory.
// head_valid says rdata currently holds the word at the read pointer; it drops
// for one cycle after every pop or flush while the new head is fetched.
module audio_fifo
  import audio_pkg::*;
#(
  parameter int LOG2_DEPTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  head_valid,
  output logic                  full,
  output logic                  empty,
  output logic [LOG2_DEPTH:0]   level
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [31:0]           mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == (LOG2_DEPTH+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && head_valid && !empty && !flush;

  // Memory write port and registered read of the current head address.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
    rdata <= mem[rd_ptr];
  end

  // Pointer, level and head-valid bookkeeping; flush equalises the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      head_valid <= 1'b0;
    end else if (flush) begin
      rd_ptr     <= wr_ptr;
      level      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + (LOG2_DEPTH+1)'(1);
      end else if (do_pop && !do_push) begin
        level <= level - (LOG2_DEPTH+1)'(1);
      end
      head_valid <= !empty && !do_pop;
    end
  end

endmodule

// File: rtl/audio_src_wb.sv
// Wishbone-programmable stereo sample source feeding the S/PDIF encoder.
// Optional feature macro: AUDIO_SRC_TONE_EN adds the TONE register and a
// built-in triangle tone generator that replaces the FIFO as sample source.
module audio_src_wb
  import audio_pkg::*;
#(
  parameter int LOG2_DEPTH = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack,
  output logic [23:0] audio_l,
  output logic [23:0] audio_r,
  output logic        valid,
  input  logic        ack
);

  wb_state_t             wb_state;
  logic                  wr_stb;
  logic                  csr_wr;
  logic                  flush;
  logic                  push;
  logic                  pop;
  logic                  underrun_evt;
  logic                  tone_active;
  logic [31:0]           tone_rd;
  logic [SAMPLE_W-1:0]   tone_sample;
  logic [31:0]           read_mux;

  logic                  enable;
  logic                  underrun;
  logic                  overflow;
  logic [7:0]            ucount;

  logic [31:0]           fifo_rdata;
  logic                  fifo_head_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LOG2_DEPTH:0]   fifo_level;

  logic                  unused_bits;
  assign unused_bits = ^{wb_addr[3:2], fifo_empty};

  assign wr_stb = (wb_state == WB_IDLE) && wb_cyc && wb_we;
  assign csr_wr = wr_stb && (wb_addr[1:0] == ADDR_CSR);
  assign flush  = csr_wr && wb_wdata[CSR_FLUSH];
  assign push   = wr_stb && (wb_addr[1:0] == ADDR_DATA) && !flush;

  assign pop = enable && !tone_active && !flush && fifo_head_valid && (!valid || ack);
  assign underrun_evt = enable && !tone_active && ack && !valid;

  audio_fifo #(
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .wdata      (wb_wdata),
    .rdata      (fifo_rdata),
    .head_valid (fifo_head_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

`ifdef AUDIO_SRC_TONE_EN
  logic [15:0] tone_step;
  logic        tone_sel;
  logic [15:0] phase;

  assign tone_active = tone_sel && enable;
  assign tone_sample = tri_sample(phase);
  assign tone_rd     = {tone_sel, 15'd0, tone_step};

  // TONE register writes and the phase accumulator stepped by each encoder ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_step <= '0;
      tone_sel  <= 1'b0;
      phase     <= '0;
    end else begin
      if (wr_stb && (wb_addr[1:0] == ADDR_TONE)) begin
        tone_step <= wb_wdata[15:0];
        tone_sel  <= wb_wdata[TONE_SEL_BIT];
      end
      if (tone_active && ack) begin
        phase <= phase + tone_step;
      end
    end
  end
`else
  assign tone_active = 1'b0;
  assign tone_sample = '0;
  assign tone_rd     = '0;
`endif

  // Read-data selection for the register map; unused addresses read zero.
  always_comb begin
    read_mux = '0;
    case (wb_addr[1:0])
      ADDR_CSR: begin
        read_mux[CSR_ENABLE]                        = enable;
        read_mux[CSR_UNDERRUN]                      = underrun;
        read_mux[CSR_OVERFLOW]                      = overflow;
        read_mux[CSR_COUNT_LO +: 8]                 = ucount;
        read_mux[CSR_LEVEL_LO +: LOG2_DEPTH+1]      = fifo_level;
      end
      ADDR_TONE: read_mux = tone_rd;
      default:   read_mux = '0;
    endcase
  end

  // Wishbone handshake: one-cycle ack after cyc is seen, never back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_state <= WB_IDLE;
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
    end else begin
      case (wb_state)
        WB_IDLE: begin
          if (wb_cyc) begin
            wb_state <= WB_ACK;
            wb_ack   <= 1'b1;
            wb_rdata <= wb_we ? 32'd0 : read_mux;
          end
        end
        WB_ACK: begin
          wb_state <= WB_IDLE;
          wb_ack   <= 1'b0;
          wb_rdata <= '0;
        end
        default: begin
          wb_state <= WB_IDLE;
          wb_ack   <= 1'b0;
          wb_rdata <= '0;
        end
      endcase
    end
  end

  // Enable bit plus the underrun/overflow stickies and saturating underrun count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= 1'b0;
      underrun <= 1'b0;
      overflow <= 1'b0;
      ucount   <= '0;
    end else begin
      if (csr_wr) begin
        enable <= wb_wdata[CSR_ENABLE];
      end
      if (csr_wr && wb_wdata[CSR_CLEAR]) begin
        underrun <= 1'b0;
        overflow <= 1'b0;
        ucount   <= '0;
      end else begin
        if (underrun_evt) begin
          underrun <= 1'b1;
          if (ucount != 8'hFF) begin
            ucount <= ucount + 8'd1;
          end
        end
        if (push && fifo_full) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Output sample register presented to the encoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_l <= '0;
      audio_r <= '0;
      valid   <= 1'b0;
    end else if (tone_active) begin
      audio_l <= {tone_sample, 8'h00};
      audio_r <= {tone_sample, 8'h00};
      valid   <= 1'b1;
    end else if (!enable || flush) begin
      valid <= 1'b0;
    end else if (pop) begin
      audio_l <= {fifo_rdata[31:16], 8'h00};
      audio_r <= {fifo_rdata[15:0], 8'h00};
      valid   <= 1'b1;
    end else if (ack && valid) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: doc/audio_src_wb.md
# audio_src_wb

Wishbone-programmable stereo sample source that feeds the S/PDIF encoder (`spdif_tx`) in the audio path. The host pushes packed 16-bit L/R samples over the USB-to-Wishbone bridge into an on-chip FIFO. The block presents one sample pair at a time on `audio_l`/`audio_r`/`valid` and advances on the encoder's `ack` pulse. It tracks underruns and overflows for host-side rate control, and optionally replaces the FIFO with a built-in triangle tone generator.

## Interface
- `LOG2_DEPTH`, 9: FIFO depth is 2^LOG2_DEPTH sample pairs (32 bits each).
- `clk`  in  1: system clock (`clk_1x` domain); the block uses this one clock only.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `wb_addr`  in  4: word address; only [1:0] decoded, [3:2] ignored.
- `wb_wdata`  in  32: write data.
- `wb_rdata`  out  32: read data; 0 except in the ack cycle of a read.
- `wb_we`  in  1: write enable.
- `wb_cyc`  in  1: cycle request; held until `wb_ack`.
- `wb_ack`  out  1: one-cycle acknowledge.
- `audio_l`  out  24: left sample, `{s16, 8'h00}`.
- `audio_r`  out  24: right sample, `{s16, 8'h00}`.
- `valid`  out  1: `audio_l`/`audio_r` hold a real sample.
- `ack`  in  1: one-cycle pulse from the encoder; current sample consumed.

## Operation
- **Register map:**
  - 0 CSR
    - W: [0] enable; [1] flush (self-clearing); [2] clear underrun/overflow stickies and counter.
    - R: [0] enable; [2] underrun sticky; [3] overflow sticky; [15:8] underrun count (8-bit, saturating at 255); [16+LOG2_DEPTH:16] FIFO level.
  - 1 DATA
    - W: push `{L=wdata[31:16], R=wdata[15:0]}`.
    - R: 0.
  - 2 TONE (macro only)
    - W/R: [15:0] phase step; [31] tone select.
  - 3: reads 0; writes ignored.
- **Output register:** `audio_l`/`audio_r`/`valid`. The register loads from the FIFO head when enabled and the FIFO is non-empty, and either `valid`=0 or `ack`=1.
- **Pop and ack:**
  - An `ack` with `valid`=1 and an empty FIFO clears `valid`.
  - An `ack` with `valid`=0 while enabled is an underrun: it sets the underrun sticky and increments the count. Underruns are not counted while disabled.
- **Disable:** enable=0 clears `valid` on the next edge and stops pops. Pushes are still accepted.
- **Push when full:** the push is dropped and the overflow sticky is set. This holds even when a pop occurs in the same cycle.
- **Simultaneous push and pop** (not full): both happen and the level is unchanged.
- **Flush:** the level goes to 0, read and write pointers are equalised, and `valid` clears. A DATA push in the same cycle as a flush is dropped (flush wins).
- **Level:** the level counter is LOG2_DEPTH+1 bits wide. Pointers are LOG2_DEPTH bits and wrap modulo depth.

## Timing
- **Reset values:** `wb_ack`=0, `wb_rdata`=0, `valid`=0, `audio_l`=`audio_r`=0, enable=0, stickies/count/level/pointers=0, tone step=0, tone select=0.
- **Wishbone:** `wb_ack` rises in the cycle after `wb_cyc` is first seen and lasts exactly one cycle. The write takes effect at that same edge. `wb_ack` never rises in two consecutive cycles.
- **FIFO:** the FIFO memory is registered-read (EBR). The first-word latency from a DATA write ack to `valid`=1 is at most 3 cycles.
- **Sample update:** after `ack`, the new sample appears at most 2 cycles later. The encoder's minimum `ack` spacing is far above this, so back-to-back acks are out of scope.

## Configuration
- `AUDIO_SRC_TONE_EN`
  - **Defined:** TONE register exists. With tone select=1 and enable=1, `valid` is held at 1. A 16-bit phase accumulator adds the step on each `ack`. The sample is a triangle: phase[15]=0 gives `{phase[14:0],1'b0}^16'h8000`, otherwise its bitwise inverse; the same value drives L and R. The FIFO is neither popped nor counted for underrun in tone mode.
  - **Not defined:** address 2 behaves like address 3, and no tone logic is synthesised.

## Structure
- **Shared package `audio_pkg`:** register address constants, CSR bit indices, and the sample-packing width constant (16).
- **Sub-module `audio_fifo`:** synchronous FIFO with push, pop, flush, full, empty and level, built on a 32-bit-wide `SB_RAM40_4K` array with LOG2_DEPTH address bits.

## Test plan
- Enable, push 0x1234_ABCD, pulse `ack` after 10 cycles → before the ack, `audio_l`=0x123400 and `audio_r`=0xABCD00 with `valid`=1; after the ack, `valid`=0 and level=0.
- Enable with an empty FIFO, pulse `ack` 3 times → CSR reads underrun sticky=1 and count=3; CSR write bit 2 → count=0 and sticky=0.
- With LOG2_DEPTH=2 and enable=0, push 5 words → level=4, overflow=1; enable, then 4 acks yield the first 4 words in order.
- Fill 3 words, write flush alongside a queued push → level=0, `valid`=0, and the pushed word is never output.
- Assert `rst_n`=0 mid-stream with level=2 and `valid`=1 → all outputs are 0 immediately (asynchronously), and level reads 0 after release.
- (`AUDIO_SRC_TONE_EN`) Set step=0x4000 with tone select=1 and pulse 4 acks → the L sample sequence follows the triangle formula and repeats every 4 acks.
